// File: rtl/puzzle_loader.sv
// puzzle_loader: draws a pseudo-random map for the requested difficulty level and presents it until acknowledged.
// Define PUZZLE_LOADER_NO_REPEAT_EN to stop the same map being drawn twice in a row on one level.
module puzzle_loader #(
    parameter int NUM_LEVELS     = 2,
    parameter int MAPS_PER_LEVEL = 8,
    parameter int CELLS          = 81,
    parameter int CELL_BITS      = 4,
    parameter int VIS_BITS       = 2,
    localparam int LW    = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int IW    = $clog2(MAPS_PER_LEVEL),
    localparam int MB    = CELLS * CELL_BITS,
    localparam int VB    = CELLS * VIS_BITS,
    localparam int TOTAL = NUM_LEVELS * MAPS_PER_LEVEL,
    localparam int SEL_W = $clog2(TOTAL)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [LW-1:0]       level,
    input  logic                ack,
    input  logic [TOTAL*MB-1:0] maps_flat,
    input  logic [TOTAL*VB-1:0] vis_flat,
    output logic [MB-1:0]       map_out,
    output logic [VB-1:0]       vis_out,
    output logic [IW-1:0]       map_index,
    output logic                busy,
    output logic                valid
);

    typedef enum logic [1:0] {S_IDLE, S_PICK, S_LOAD, S_PRESENT} state_t;

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [LW-1:0]  lvl_q, lvl_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [MB-1:0]  map_q, map_d;
    logic [VB-1:0]  vis_q, vis_d;
    logic [IW-1:0]  map_index_q, map_index_d;
    logic           valid_q, valid_d;

    logic [MB-1:0]    map_lib [TOTAL];
    logic [VB-1:0]    vis_lib [TOTAL];
    logic [SEL_W-1:0] sel;
    logic [IW-1:0]    draw, pick_idx;

    // Library viewed as an array so the LOAD mux is a plain indexed read.
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_lib
        assign map_lib[gi] = maps_flat[gi*MB +: MB];
        assign vis_lib[gi] = vis_flat[gi*VB +: VB];
    end

    assign sel  = SEL_W'(32'(lvl_q) * MAPS_PER_LEVEL + 32'(idx_q));
    assign draw = lfsr_q[IW-1:0];

`ifdef PUZZLE_LOADER_NO_REPEAT_EN
    logic [IW-1:0]         last_idx_q [NUM_LEVELS];
    logic [NUM_LEVELS-1:0] last_vld_q;
    logic                  repeat_hit;

    assign repeat_hit = last_vld_q[lvl_q] && (last_idx_q[lvl_q] == draw);
    assign pick_idx   = repeat_hit ? draw + IW'(1) : draw;

    for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_last
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                last_idx_q[gi] <= '0;
                last_vld_q[gi] <= 1'b0;
            end else if (state_q == S_LOAD && lvl_q == LW'(gi)) begin
                last_idx_q[gi] <= idx_q;
                last_vld_q[gi] <= 1'b1;
            end
        end
    end
`else
    assign pick_idx = draw;
`endif

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        lvl_d       = lvl_q;
        idx_d       = idx_q;
        map_d       = map_q;
        vis_d       = vis_q;
        map_index_d = map_index_q;
        valid_d     = valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    lvl_d   = (32'(level) >= NUM_LEVELS) ? LW'(NUM_LEVELS - 1) : level;
                    state_d = S_PICK;
                end
            end
            S_PICK: begin
                idx_d   = pick_idx;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                map_d       = map_lib[sel];
                vis_d       = vis_lib[sel];
                map_index_d = idx_q;
                valid_d     = 1'b1;
                state_d     = S_PRESENT;
            end
            S_PRESENT: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= 16'hACE1;
            lvl_q       <= '0;
            idx_q       <= '0;
            map_q       <= '0;
            vis_q       <= '0;
            map_index_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            lvl_q       <= lvl_d;
            idx_q       <= idx_d;
            map_q       <= map_d;
            vis_q       <= vis_d;
            map_index_q <= map_index_d;
            valid_q     <= valid_d;
        end
    end

    assign map_out   = map_q;
    assign vis_out   = vis_q;
    assign map_index = map_index_q;
    assign valid     = valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_puzzle_loader.sv
// Randomized bench for puzzle_loader: a transaction-level model predicts every output each cycle.
module tb_puzzle_loader;
    localparam int NL    = 2;
    localparam int MPL   = 8;
    localparam int CELLS = 81;
    localparam int LW    = 1;
    localparam int IW    = 3;
    localparam int MB    = CELLS * 4;
    localparam int VB    = CELLS * 2;
    localparam int TOTAL = NL * MPL;
    localparam int SEL_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req = 1'b0;
    logic ack = 1'b0;
    logic [LW-1:0] level = '0;
    logic [TOTAL*MB-1:0] maps_flat;
    logic [TOTAL*VB-1:0] vis_flat;
    logic [MB-1:0] map_out;
    logic [VB-1:0] vis_out;
    logic [IW-1:0] map_index;
    logic busy, valid;

    logic [MB-1:0] lib_map [TOTAL];
    logic [VB-1:0] lib_vis [TOTAL];

    int n_vec = 0;
    int n_err = 0;
    int n_loads = 0;

    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_flat
        assign maps_flat[gi*MB +: MB] = lib_map[gi];
        assign vis_flat[gi*VB +: VB]  = lib_vis[gi];
    end

    puzzle_loader #(
        .NUM_LEVELS(NL), .MAPS_PER_LEVEL(MPL), .CELLS(CELLS), .CELL_BITS(4), .VIS_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .level(level), .ack(ack),
        .maps_flat(maps_flat), .vis_flat(vis_flat),
        .map_out(map_out), .vis_out(vis_out), .map_index(map_index),
        .busy(busy), .valid(valid)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [MB-1:0] act, input logic [MB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Model: a request drawn at edge N uses the LFSR value seen at edge N+1; the map appears at edge N+2.
    logic [15:0]   m_lfsr, m_draw;
    int            m_wait, m_lvl;
    logic          m_busy, m_valid;
    logic [IW-1:0] m_idx;
    logic [MB-1:0] m_map;
    logic [VB-1:0] m_vis;
`ifdef PUZZLE_LOADER_NO_REPEAT_EN
    logic [IW-1:0] m_last [NL];
    logic          m_lastv [NL];
`endif

    task automatic model_reset();
        m_lfsr = 16'hACE1; m_draw = '0; m_wait = 0; m_lvl = 0;
        m_busy = 1'b0; m_valid = 1'b0; m_idx = '0; m_map = '0; m_vis = '0;
`ifdef PUZZLE_LOADER_NO_REPEAT_EN
        for (int i = 0; i < NL; i++) begin
            m_last[i] = '0;
            m_lastv[i] = 1'b0;
        end
`endif
    endtask

    task automatic model_step();
        logic [IW-1:0] idx;
        int sel;
        if (!m_busy) begin
            if (req) begin
                m_busy = 1'b1;
                m_lvl  = (int'(level) >= NL) ? NL - 1 : int'(level);
                m_draw = step(m_lfsr);
                m_wait = 1;
            end
        end else if (!m_valid) begin
            if (m_wait > 0) begin
                m_wait--;
            end else begin
                idx = m_draw[IW-1:0];
`ifdef PUZZLE_LOADER_NO_REPEAT_EN
                if (m_lastv[m_lvl] && m_last[m_lvl] == idx) idx = idx + IW'(1);
                m_last[m_lvl]  = idx;
                m_lastv[m_lvl] = 1'b1;
`endif
                m_idx   = idx;
                sel     = m_lvl * MPL + int'(idx);
                m_map   = lib_map[SEL_W'(sel)];
                m_vis   = lib_vis[SEL_W'(sel)];
                m_valid = 1'b1;
                $display("load %0d: level %0d map %0d", n_loads, m_lvl, idx);
                n_loads++;
            end
        end else if (ack) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
        end
        m_lfsr = step(m_lfsr);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("valid", MB'(valid), MB'(m_valid));
        chk("busy", MB'(busy), MB'(m_busy));
        chk("map_index", MB'(map_index), MB'(m_idx));
        chk("map_out", map_out, m_map);
        chk("vis_out", MB'(vis_out), MB'(m_vis));
    end

    // Known draw after release: LFSR at edge 4 is 16'h559C, so a request on edge 3 presents map 4.
    task automatic pinned_load();
        @(negedge clk);
        @(negedge clk);
        req = 1'b1; level = '0;
        @(negedge clk);
        req = 1'b0;
        chk("pin_busy1", MB'(busy), MB'(1'b1));
        chk("pin_valid1", MB'(valid), MB'(1'b0));
        @(negedge clk);
        chk("pin_busy2", MB'(busy), MB'(1'b1));
        chk("pin_valid2", MB'(valid), MB'(1'b0));
        @(negedge clk);
        chk("pin_valid3", MB'(valid), MB'(1'b1));
        chk("pin_busy3", MB'(busy), MB'(1'b1));
        chk("pin_index", MB'(map_index), MB'(3'd4));
        chk("pin_map", map_out, lib_map[4]);
        chk("pin_vis", MB'(vis_out), MB'(lib_vis[4]));
    endtask

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            req   = ($urandom_range(0, 3) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            level = LW'($urandom);
        end
        @(negedge clk);
        req = 1'b0; ack = 1'b1;
        repeat (5) @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        logic [MB-1:0] tm;
        logic [VB-1:0] tv;
        tm = '0; tv = '0;
        for (int i = 0; i < TOTAL; i++) begin
            for (int w = 0; w < (MB + 31) / 32; w++) tm = {tm[MB-33:0], $urandom};
            for (int w = 0; w < (VB + 31) / 32; w++) tv = {tv[VB-33:0], $urandom};
            lib_map[SEL_W'(i)] = tm;
            lib_vis[SEL_W'(i)] = tv;
        end

        repeat (3) @(negedge clk);
        chk("rst_valid", MB'(valid), MB'(1'b0));
        chk("rst_busy", MB'(busy), MB'(1'b0));
        chk("rst_index", MB'(map_index), MB'(3'd0));
        chk("rst_map", map_out, '0);
        reset = 1'b0;
        pinned_load();

        repeat (20) @(negedge clk);
        chk("hold_valid", MB'(valid), MB'(1'b1));
        chk("hold_index", MB'(map_index), MB'(3'd4));
        chk("hold_map", map_out, lib_map[4]);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_valid", MB'(valid), MB'(1'b0));
        chk("ack_busy", MB'(busy), MB'(1'b0));
        chk("retain_map", map_out, lib_map[4]);

        @(negedge clk);
        req = 1'b1; level = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        random_phase(600);

        @(negedge clk);
        req = 1'b1; level = '0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_valid", MB'(valid), MB'(1'b0));
        chk("abort_busy", MB'(busy), MB'(1'b0));
        chk("abort_map", map_out, '0);
        chk("abort_index", MB'(map_index), MB'(3'd0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pinned_load();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        random_phase(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
